niosiisystem_sw_in: RTL

NIOSIISYSTEM_SW_IN -- requirements
Module: niosiisystem_sw_in

---
 rtl/niosiisystem_sw_in.sv | 105 ++++++++++
 1 files changed

// File: rtl/niosiisystem_sw_in.sv
// Avalon-MM switch/key input port: 2-flop synchronizer, DATA/IRQMASK/EDGECAP registers and a level irq.
// Define NIOSIISYSTEM_SW_IN_DEBOUNCE_EN to add a per-bit debounce filter of DEBOUNCE_CYCLES stable cycles.
module niosiisystem_sw_in #(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] cap_clr;
  logic [1:0]       arm_cnt;
  logic             armed;
  logic             wr_en;
  logic             unused_wdata;

  assign armed        = (arm_cnt == 2'd3);
  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

`ifdef NIOSIISYSTEM_SW_IN_DEBOUNCE_EN
  localparam int unsigned          CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] db_cnt [WIDTH];

  // Counter tracks consecutive cycles where sync2 disagrees with the filtered value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filt <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else if (!armed) begin
      filt <= sync2;
      for (int unsigned i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_MAX) begin
          filt[i]   <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  logic unused_cfg;

  assign filt       = sync2;
  assign unused_cfg = (DEBOUNCE_CYCLES == 0);
`endif

  // Edges are ignored until arming completes so inputs already high at reset release do not capture.
  always_comb begin
    rise    = armed ? (filt & ~prev) : '0;
    cap_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
      arm_cnt  <= '0;
    end else begin
      sync1    <= in_port;
      sync2    <= sync1;
      prev     <= armed ? filt : sync2;
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
      if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
      edge_cap <= (edge_cap & ~cap_clr) | rise;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = filt;
      2'd2:    readdata[WIDTH-1:0] = irq_mask;
      2'd3:    readdata[WIDTH-1:0] = edge_cap;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edge_cap & irq_mask);

endmodule
